// File: rtl/ppg_pkg.sv
// Shared types and constants for the PPG front-end (DC-comp/PGA controller and channel demux).
package ppg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    PUBLISH
  } ppg_state_e;

  localparam logic CHAN_IR  = 1'b0;
  localparam logic CHAN_RED = 1'b1;

  localparam int unsigned ADC_W_DEF = 8;
  localparam logic [ADC_W_DEF-1:0] ADC_MAX = '1;

endpackage

// File: rtl/ppg_channel_demux_if.sv
// Sample-stream / result bus of ppg_channel_demux.
// PPG_SAT_DETECT_EN adds the ir_sat/red_sat flags.
interface ppg_channel_demux_if #(
  parameter int unsigned ADC_W = 8
);

  logic             meas_en;
  logic             sample_en;
  logic [ADC_W-1:0] adc;
  logic             led_ir;
  logic             led_red;
  logic [ADC_W-1:0] ir_dc;
  logic [ADC_W-1:0] ir_ac;
  logic [ADC_W-1:0] red_dc;
  logic [ADC_W-1:0] red_ac;
  logic             result_valid;
  logic             result_chan;
  logic             chan_err;
`ifdef PPG_SAT_DETECT_EN
  logic             ir_sat;
  logic             red_sat;

  modport master (
    output meas_en, sample_en, adc, led_ir, led_red,
    input  ir_dc, ir_ac, red_dc, red_ac, result_valid, result_chan, chan_err,
    input  ir_sat, red_sat
  );

  modport slave (
    input  meas_en, sample_en, adc, led_ir, led_red,
    output ir_dc, ir_ac, red_dc, red_ac, result_valid, result_chan, chan_err,
    output ir_sat, red_sat
  );
`else
  modport master (
    output meas_en, sample_en, adc, led_ir, led_red,
    input  ir_dc, ir_ac, red_dc, red_ac, result_valid, result_chan, chan_err
  );

  modport slave (
    input  meas_en, sample_en, adc, led_ir, led_red,
    output ir_dc, ir_ac, red_dc, red_ac, result_valid, result_chan, chan_err
  );
`endif

endinterface

// File: rtl/ppg_window_stats.sv
// Window accumulator: sum/min/max/count (plus saturation flag under PPG_SAT_DETECT_EN).
// Result outputs already include the sample being added this cycle; clear beats add.
module ppg_window_stats #(
  parameter int unsigned ADC_W    = 8,
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      add,
  input  logic [ADC_W-1:0]          sample,
  output logic [ADC_W+WIN_LOG2-1:0] sum_o,
  output logic [ADC_W-1:0]          min_o,
  output logic [ADC_W-1:0]          max_o,
  output logic                      done_o
`ifdef PPG_SAT_DETECT_EN
  ,
  output logic                      sat_o
`endif
);

  localparam int unsigned SUM_W = ADC_W + WIN_LOG2;

  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d, sum_upd;
  logic [ADC_W-1:0]    min_q, min_d, min_upd;
  logic [ADC_W-1:0]    max_q, max_d, max_upd;
`ifdef PPG_SAT_DETECT_EN
  logic                sat_q, sat_d, sat_upd;
`endif

  always_comb begin
    sum_upd = sum_q + SUM_W'(sample);
    min_upd = (sample < min_q) ? sample : min_q;
    max_upd = (sample > max_q) ? sample : max_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
`ifdef PPG_SAT_DETECT_EN
    sat_upd = sat_q | (sample == '0) | (sample == '1);
    sat_d   = sat_q;
`endif
    if (clear) begin
      cnt_d = '0;
      sum_d = '0;
      min_d = '1;
      max_d = '0;
`ifdef PPG_SAT_DETECT_EN
      sat_d = 1'b0;
`endif
    end else if (add) begin
      cnt_d = cnt_q + WIN_LOG2'(1);
      sum_d = sum_upd;
      min_d = min_upd;
      max_d = max_upd;
`ifdef PPG_SAT_DETECT_EN
      sat_d = sat_upd;
`endif
    end
    sum_o  = add ? sum_upd : sum_q;
    min_o  = add ? min_upd : min_q;
    max_o  = add ? max_upd : max_q;
    done_o = add && (cnt_q == '1);
`ifdef PPG_SAT_DETECT_EN
    sat_o  = add ? sat_upd : sat_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
`ifdef PPG_SAT_DETECT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
`ifdef PPG_SAT_DETECT_EN
      sat_q <= sat_d;
`endif
    end
  end

endmodule

// File: rtl/ppg_channel_demux.sv
// Splits the ADC stream into IR/RED windows, drops settling samples, publishes DC/AC per channel.
// PPG_SAT_DETECT_EN adds per-channel saturation flags.
module ppg_channel_demux
  import ppg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WIN_LOG2      = 6,
  parameter int unsigned ADC_W         = ADC_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  ppg_channel_demux_if.slave bus
);

  localparam int unsigned SUM_W = ADC_W + WIN_LOG2;
  localparam int unsigned SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  ppg_state_e       state_q, state_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [1:0]       led_q, led_d;
  logic [ADC_W-1:0] ir_dc_q, ir_dc_d, ir_ac_q, ir_ac_d;
  logic [ADC_W-1:0] red_dc_q, red_dc_d, red_ac_q, red_ac_d;
  logic             result_chan_q, result_chan_d;
  logic             chan_err_q, chan_err_d;
`ifdef PPG_SAT_DETECT_EN
  logic             ir_sat_q, ir_sat_d, red_sat_q, red_sat_d;
  logic             st_sat;
`endif

  logic             sel_ok, invalid, led_change, accumulating, publish, pub_chan;
  logic             st_clear, st_add, st_done;
  logic [SUM_W-1:0] st_sum;
  logic [ADC_W-1:0] st_min, st_max, pub_dc, pub_ac;

  ppg_window_stats #(
    .ADC_W    (ADC_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_stats (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (st_clear),
    .add    (st_add),
    .sample (bus.adc),
    .sum_o  (st_sum),
    .min_o  (st_min),
    .max_o  (st_max),
    .done_o (st_done)
`ifdef PPG_SAT_DETECT_EN
    ,
    .sat_o  (st_sat)
`endif
  );

  always_comb begin
    led_d        = {bus.led_red, bus.led_ir};
    sel_ok       = bus.led_ir ^ bus.led_red;
    invalid      = !bus.meas_en || !sel_ok;
    led_change   = led_q != led_d;
    accumulating = (state_q == ACCUM) || (state_q == PUBLISH);
    st_add       = accumulating && bus.sample_en;
    // the completing sample is captured into the outputs on the same edge the window clears,
    // so PUBLISH can already accept the first sample of the next window
    publish      = accumulating && !invalid && !led_change && st_done;
    st_clear     = !accumulating || invalid || led_change || st_done;
    pub_chan     = led_q[1] ? CHAN_RED : CHAN_IR;
    pub_dc       = ADC_W'(st_sum >> WIN_LOG2);
    pub_ac       = st_max - st_min;
    chan_err_d   = bus.meas_en && !sel_ok;

    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (!invalid) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (invalid) begin
          state_d = IDLE;
        end else if (led_change) begin
          settle_d = '0;
        end else if (bus.sample_en) begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ACCUM;
          end else begin
            settle_d = settle_q + SC_W'(1);
          end
        end
      end
      ACCUM, PUBLISH: begin
        if (invalid) begin
          state_d = IDLE;
        end else if (led_change) begin
          state_d  = SETTLE;
          settle_d = '0;
        end else if (publish) begin
          state_d = PUBLISH;
        end else begin
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase

    ir_dc_d       = ir_dc_q;
    ir_ac_d       = ir_ac_q;
    red_dc_d      = red_dc_q;
    red_ac_d      = red_ac_q;
    result_chan_d = result_chan_q;
`ifdef PPG_SAT_DETECT_EN
    ir_sat_d      = ir_sat_q;
    red_sat_d     = red_sat_q;
`endif
    if (publish) begin
      result_chan_d = pub_chan;
      if (pub_chan == CHAN_RED) begin
        red_dc_d  = pub_dc;
        red_ac_d  = pub_ac;
`ifdef PPG_SAT_DETECT_EN
        red_sat_d = st_sat;
`endif
      end else begin
        ir_dc_d   = pub_dc;
        ir_ac_d   = pub_ac;
`ifdef PPG_SAT_DETECT_EN
        ir_sat_d  = st_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      led_q         <= '0;
      ir_dc_q       <= '0;
      ir_ac_q       <= '0;
      red_dc_q      <= '0;
      red_ac_q      <= '0;
      result_chan_q <= 1'b0;
      chan_err_q    <= 1'b0;
`ifdef PPG_SAT_DETECT_EN
      ir_sat_q      <= 1'b0;
      red_sat_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      led_q         <= led_d;
      ir_dc_q       <= ir_dc_d;
      ir_ac_q       <= ir_ac_d;
      red_dc_q      <= red_dc_d;
      red_ac_q      <= red_ac_d;
      result_chan_q <= result_chan_d;
      chan_err_q    <= chan_err_d;
`ifdef PPG_SAT_DETECT_EN
      ir_sat_q      <= ir_sat_d;
      red_sat_q     <= red_sat_d;
`endif
    end
  end

  assign bus.ir_dc        = ir_dc_q;
  assign bus.ir_ac        = ir_ac_q;
  assign bus.red_dc       = red_dc_q;
  assign bus.red_ac       = red_ac_q;
  assign bus.result_valid = (state_q == PUBLISH);
  assign bus.result_chan  = result_chan_q;
  assign bus.chan_err     = chan_err_q;
`ifdef PPG_SAT_DETECT_EN
  assign bus.ir_sat       = ir_sat_q;
  assign bus.red_sat      = red_sat_q;
`endif

endmodule
